reg_writeback_queue: RTL and testbench

REG_WRITEBACK_QUEUE -- requirements
Module: reg_writeback_queue

---
 rtl/wbq_pkg.sv | 15 +
 rtl/wbq_match.sv | 37 +++
 rtl/reg_writeback_queue.sv | 127 ++++++++++++
 tb/tb_reg_writeback_queue.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wbq_pkg.sv
// Shared sizes and types for the register writeback queue.
package wbq_pkg;

  localparam int WBQ_DEPTH = 4;
  localparam int WBQ_XLEN  = 32;
  localparam int REG_W     = 5;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t              rd;
    logic [WBQ_XLEN-1:0]   data;
  } wbq_entry_t;

endpackage

// File: rtl/wbq_match.sv
// Youngest-first forwarding search over the occupied queue entries.
module wbq_match
  import wbq_pkg::*;
#(
  parameter  int DEPTH = WBQ_DEPTH,
  parameter  int XLEN  = WBQ_XLEN,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  reg_idx_t         rd_i   [DEPTH],
  input  logic [XLEN-1:0]  data_i [DEPTH],
  input  logic [PTR_W-1:0] head_i,
  input  logic [CNT_W-1:0] count_i,
  input  reg_idx_t         addr_i,
  output logic             hit_o,
  output logic [XLEN-1:0]  data_o
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_i + PTR_W'(i);
      if (CNT_W'(i) < count_i &&
          addr_i != '0 &&
          rd_i[idx] == addr_i) begin
        hit_o  = 1'b1;
        data_o = data_i[idx];
      end
    end
  end

endmodule

// File: rtl/reg_writeback_queue.sv
// Pending register-write FIFO with optional read-stage forwarding.
// Forwarding lookups are built only when WBQ_FORWARD_EN is defined.
module reg_writeback_queue
  import wbq_pkg::*;
#(
  parameter  int DEPTH = WBQ_DEPTH,
  parameter  int XLEN  = WBQ_XLEN,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [REG_W-1:0] push_rd,
  input  logic [XLEN-1:0]  push_data,
  input  logic             rf_grant,
  output logic             rf_we,
  output logic [REG_W-1:0] rf_addr,
  output logic [XLEN-1:0]  rf_wdata,
  input  logic [REG_W-1:0] q1_addr,
  input  logic [REG_W-1:0] q2_addr,
  output logic             q1_hit,
  output logic             q2_hit,
  output logic [XLEN-1:0]  q1_data,
  output logic [XLEN-1:0]  q2_data,
  output logic [CNT_W-1:0] count
);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  reg_idx_t        rd_q   [DEPTH];
  reg_idx_t        rd_d   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] data_d [DEPTH];

  logic push_en;
  logic pop;

  assign push_ready = (count_q != CNT_W'(DEPTH));
  assign rf_we      = (count_q != '0) && rf_grant;
  assign pop        = rf_we;
  // x0 writes complete the handshake but are dropped here.
  assign push_en    = push_valid && push_ready &&
                      (push_rd != '0);

  assign rf_addr  = rd_q[head_q];
  assign rf_wdata = data_q[head_q];
  assign count    = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    rd_d    = rd_q;
    data_d  = data_q;
    if (push_en) begin
      rd_d[tail_q]   = push_rd;
      data_d[tail_q] = push_data;
      tail_d         = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    unique case ({push_en, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage is left unreset; count gates validity.
  always_ff @(posedge clk) begin
    rd_q   <= rd_d;
    data_q <= data_d;
  end

`ifdef WBQ_FORWARD_EN
  wbq_match #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_match_q1 (
    .rd_i    (rd_q),
    .data_i  (data_q),
    .head_i  (head_q),
    .count_i (count_q),
    .addr_i  (q1_addr),
    .hit_o   (q1_hit),
    .data_o  (q1_data)
  );

  wbq_match #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_match_q2 (
    .rd_i    (rd_q),
    .data_i  (data_q),
    .head_i  (head_q),
    .count_i (count_q),
    .addr_i  (q2_addr),
    .hit_o   (q2_hit),
    .data_o  (q2_data)
  );
`else
  logic unused_lookup;
  assign unused_lookup = ^{q1_addr, q2_addr};
  assign q1_hit  = 1'b0;
  assign q2_hit  = 1'b0;
  assign q1_data = '0;
  assign q2_data = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue (DEPTH=4, XLEN=32).
module tb_reg_writeback_queue;

`ifdef WBQ_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        push_valid;
  logic        push_ready;
  logic [4:0]  push_rd;
  logic [31:0] push_data;
  logic        rf_grant;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic [4:0]  q1_addr, q2_addr;
  logic        q1_hit, q2_hit;
  logic [31:0] q1_data, q2_data;
  logic [2:0]  count;

  int n_chk  = 0;
  int n_fail = 0;

  reg_writeback_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_rd    (push_rd),
    .push_data  (push_data),
    .rf_grant   (rf_grant),
    .rf_we      (rf_we),
    .rf_addr    (rf_addr),
    .rf_wdata   (rf_wdata),
    .q1_addr    (q1_addr),
    .q2_addr    (q2_addr),
    .q1_hit     (q1_hit),
    .q2_hit     (q2_hit),
    .q1_data    (q1_data),
    .q2_data    (q2_data),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] rd,
                      input logic [31:0] d);
    push_valid = 1'b1;
    push_rd    = rd;
    push_data  = d;
    tick();
    push_valid = 1'b0;
  endtask

  logic [36:0] exp_q[$];
  logic [36:0] ent;

  initial begin
    rst        = 1'b1;
    push_valid = 1'b0;
    push_rd    = '0;
    push_data  = '0;
    rf_grant   = 1'b1;
    q1_addr    = '0;
    q2_addr    = '0;
    #3;
    chk("rst_count", count, 0);
    chk("rst_ready", push_ready, 1);
    chk("rst_we", rf_we, 0);
    chk("rst_q1hit", q1_hit, 0);
    chk("rst_q2hit", q2_hit, 0);
    tick();
    rst      = 1'b0;
    rf_grant = 1'b0;
    tick();

    // single push, forwarded lookup
    push(5'd5, 32'hDEADBEEF);
    q1_addr = 5'd5;
    q2_addr = 5'd6;
    #1;
    chk("p1_count", count, 1);
    chk("p1_we", rf_we, 0);
    chk("p1_q1hit", q1_hit, FWD);
    chk("p1_q1data", q1_data, FWD ? 32'hDEADBEEF : 0);
    chk("p1_q2hit", q2_hit, 0);
    rf_grant = 1'b1;
    #1;
    chk("p1_rfwe", rf_we, 1);
    chk("p1_addr", rf_addr, 5);
    chk("p1_wdata", rf_wdata, 32'hDEADBEEF);
    tick();
    rf_grant = 1'b0;
    chk("p1_empty", count, 0);

    // same rd twice: youngest wins, order kept
    push(5'd3, 32'd1);
    push_valid = 1'b1;
    push_rd    = 5'd3;
    push_data  = 32'd2;
    q2_addr    = 5'd3;
    #1;
    chk("p2_samecyc", q2_data, FWD ? 32'd1 : 0);
    tick();
    push_valid = 1'b0;
    q1_addr    = 5'd3;
    q2_addr    = 5'd7;
    #1;
    chk("p2_young", q1_data, FWD ? 32'd2 : 0);
    chk("p2_q2miss", q2_hit, 0);
    rf_grant = 1'b1;
    #1;
    chk("p2_w0addr", rf_addr, 3);
    chk("p2_w0data", rf_wdata, 1);
    chk("p2_popfwd", q1_data, FWD ? 32'd2 : 0);
    tick();
    chk("p2_w1we", rf_we, 1);
    chk("p2_w1data", rf_wdata, 2);
    tick();
    rf_grant = 1'b0;
    #1;
    chk("p2_empty", count, 0);

    // fill to full, reject extra, one pop frees a slot
    for (int k = 1; k <= 4; k++)
      push(5'(k), 32'(k + 9));
    chk("f_ready", push_ready, 0);
    chk("f_count", count, 4);
    push_valid = 1'b1;
    push_rd    = 5'd20;
    push_data  = 32'd99;
    tick();
    chk("f_ignored", count, 4);
    rf_grant = 1'b1;
    #1;
    chk("f_ready_pop", push_ready, 0);
    tick();
    push_valid = 1'b0;
    rf_grant   = 1'b0;
    #1;
    chk("f_ready_nxt", push_ready, 1);
    chk("f_cnt3", count, 3);
    rf_grant = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      #1;
      chk("f_daddr", rf_addr, k);
      chk("f_ddata", rf_wdata, k + 9);
      tick();
    end
    rf_grant = 1'b0;
    chk("f_empty", count, 0);

    // x0 write is swallowed
    push_valid = 1'b1;
    push_rd    = 5'd0;
    push_data  = 32'h55;
    #1;
    chk("x0_ready", push_ready, 1);
    tick();
    push_valid = 1'b0;
    rf_grant   = 1'b1;
    q1_addr    = 5'd0;
    #1;
    chk("x0_count", count, 0);
    chk("x0_we", rf_we, 0);
    chk("x0_q1hit", q1_hit, 0);
    rf_grant = 1'b0;

    // steady push+pop at count 2 over many wraps
    push(5'd6, 32'hA);
    push(5'd7, 32'hB);
    exp_q.push_back({5'd6, 32'hA});
    exp_q.push_back({5'd7, 32'hB});
    rf_grant = 1'b1;
    for (int k = 0; k < 48; k++) begin
      push_valid = 1'b1;
      push_rd    = 5'((k % 31) + 1);
      push_data  = 32'(k * 32'h1111 + 32'h100);
      #1;
      ent = exp_q.pop_front();
      chk("w_count", count, 2);
      chk("w_addr", rf_addr, ent[36:32]);
      chk("w_data", rf_wdata, ent[31:0]);
      exp_q.push_back({push_rd, push_data});
      tick();
    end
    push_valid = 1'b0;
    while (exp_q.size() != 0) begin
      ent = exp_q.pop_front();
      #1;
      chk("w_daddr", rf_addr, ent[36:32]);
      chk("w_ddata", rf_wdata, ent[31:0]);
      tick();
    end
    rf_grant = 1'b0;
    chk("w_empty", count, 0);

    // async reset mid-drain discards pending entries
    for (int k = 8; k <= 11; k++)
      push(5'(k), 32'(k));
    rf_grant = 1'b1;
    tick();
    chk("r_cnt3", count, 3);
    q1_addr = 5'd9;
    #2;
    rst = 1'b1;
    #1;
    chk("r_count", count, 0);
    chk("r_we", rf_we, 0);
    chk("r_ready", push_ready, 1);
    chk("r_q1hit", q1_hit, 0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("r_nowrite", rf_we, 0);
      tick();
    end
    chk("r_final", count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
